// File: rtl/instr_fetch.sv
// Instruction fetch unit: walks IDLE -> FETCH -> EXEC, computes the next PC from
// branch/jump decode and traps to a sticky ERROR state on memory timeout or misaligned target.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        beq,
    input  logic        zero,
    input  logic        j,
    input  logic        jal,
    input  logic        jr,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] order,
    output logic        order_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StError} state_e;

    state_e          state;
    logic [CntW-1:0] wait_cnt;
    logic [31:0]     br_off;
    logic [31:0]     next_pc;

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign imem_req    = (state == StFetch);
    assign order_valid = (state == StExec);

    always_comb begin
        br_off  = {{14{order[15]}}, order[15:0], 2'b00};
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = rs_data;
        end else if (j || jal) begin
            next_pc = {pc_plus4[31:28], order[25:0], 2'b00};
        end else if (beq && zero) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            pc        <= RESET_PC;
            order     <= '0;
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            unique case (state)
                StIdle: state <= StFetch;
                StFetch: begin
                    if (imem_ack) begin
                        order    <= imem_rdata;
                        wait_cnt <= '0;
                        state    <= StExec;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // This miss is the MAX_WAIT-th consecutive one.
                        if (wait_cnt == CntW'(MAX_WAIT - 1)) begin
                            state     <= StError;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                StExec: begin
                    if (!stall) begin
                        if (next_pc[1:0] != 2'b00) begin
                            state     <= StError;
                            fetch_err <= 1'b1;
                        end else begin
                            pc    <= next_pc;
                            state <= StFetch;
                        end
                    end
                end
                StError: state <= StError;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a behavioural model, plus directed literal cases.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          MAXW   = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        beq = 1'b0, zero = 1'b0, j = 1'b0, jal = 1'b0, jr = 1'b0, stall = 1'b0;
    logic [31:0] rs_data = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] order;
    logic        order_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    instr_fetch #(.RESET_PC(RST_PC), .MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .beq        (beq),
        .zero       (zero),
        .j          (j),
        .jal        (jal),
        .jr         (jr),
        .rs_data    (rs_data),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .order      (order),
        .order_valid(order_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 waiting for memory, 2 executing, 3 dead.
    int          phase;
    logic [31:0] mpc;
    logic [31:0] morder;
    int          mwait;
    logic        merr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("m_req",   {31'b0, imem_req},    {31'b0, phase == 1});
        check("m_valid", {31'b0, order_valid}, {31'b0, phase == 2});
        check("m_addr",  imem_addr, mpc);
        check("m_pc",    pc, mpc);
        check("m_pc4",   pc_plus4, mpc + 32'd4);
        check("m_err",   {31'b0, fetch_err}, {31'b0, merr});
        check("m_order", order, morder);
    endtask

    task automatic model_step();
        logic [31:0] p4, tgt;
        p4 = mpc + 32'd4;
        case (phase)
            0: phase = 1;
            1: begin
                if (imem_ack) begin
                    morder = imem_rdata;
                    mwait  = 0;
                    phase  = 2;
                end else begin
                    mwait++;
                    if (mwait == MAXW) begin
                        phase = 3;
                        merr  = 1'b1;
                    end
                end
            end
            2: begin
                if (!stall) begin
                    if (jr)               tgt = rs_data;
                    else if (j || jal)    tgt = {p4[31:28], morder[25:0], 2'b00};
                    else if (beq && zero) tgt = p4 + (32'($signed(morder[15:0])) << 2);
                    else                  tgt = p4;
                    if (tgt % 4 != 0) begin
                        phase = 3;
                        merr  = 1'b1;
                    end else begin
                        mpc   = tgt;
                        phase = 1;
                    end
                end
            end
            default: phase = 3;
        endcase
    endtask

    task automatic cycle(input logic a, input logic [31:0] rd, input logic b, input logic z,
                         input logic jj, input logic jl, input logic jrr,
                         input logic [31:0] rs, input logic st);
        imem_ack = a; imem_rdata = rd; beq = b; zero = z; j = jj; jal = jl; jr = jrr;
        rs_data = rs; stall = st;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic nop(input logic a, input logic [31:0] rd);
        cycle(a, rd, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Reset is asserted away from any clock edge, so the checks prove it acts asynchronously.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_pc",    pc, RST_PC);
        check("rst_req",   {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, order_valid}, 32'h0);
        check("rst_err",   {31'b0, fetch_err}, 32'h0);
        check("rst_order", order, 32'h0);
        phase = 0; mpc = RST_PC; morder = '0; mwait = 0; merr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_model();
    endtask

    initial begin
        int vcount;
        int dead;
        phase = 0; mpc = RST_PC; morder = '0; mwait = 0; merr = 1'b0;
        @(negedge clk);
        do_reset();
        check("idle_req", {31'b0, imem_req}, 32'h0);
        nop(1'b0, 32'h0);
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("addr0", imem_addr, 32'h0000_3000);

        // NOP stream, memory acks every request
        nop(1'b1, 32'h0);
        check("valid_e0", {31'b0, order_valid}, 32'h1);
        nop(1'b0, 32'h0);
        check("addr1", imem_addr, 32'h0000_3004);
        check("valid_f1", {31'b0, order_valid}, 32'h0);
        nop(1'b1, 32'h0);
        nop(1'b0, 32'h0);
        check("addr2", imem_addr, 32'h0000_3008);

        // beq with offset -1
        do_reset();
        nop(1'b0, 32'h0);
        nop(1'b1, 32'h1000_FFFF);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("beq_taken", pc, 32'h0000_3000);
        nop(1'b1, 32'h1000_FFFF);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("beq_not", pc, 32'h0000_3004);

        // jal outranks beq
        do_reset();
        nop(1'b0, 32'h0);
        nop(1'b1, 32'h0C00_0C10);
        check("jal_pc4", pc_plus4, 32'h0000_3004);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("jal_pc", pc, 32'h0000_3040);

        // misaligned jr traps
        do_reset();
        nop(1'b0, 32'h0);
        nop(1'b1, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3002, 1'b0);
        check("jr_err", {31'b0, fetch_err}, 32'h1);
        check("jr_pc", pc, 32'h0000_3000);
        repeat (4) nop(1'b1, 32'hFFFF_FFFF);
        check("jr_dead_req", {31'b0, imem_req}, 32'h0);
        check("jr_dead_pc", pc, 32'h0000_3000);
        do_reset();
        nop(1'b0, 32'h0);
        nop(1'b1, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3100, 1'b0);
        check("jr_ok", pc, 32'h0000_3100);

        // memory timeout
        do_reset();
        nop(1'b0, 32'h0);
        repeat (MAXW - 1) nop(1'b0, 32'h0);
        check("to_not_yet", {31'b0, fetch_err}, 32'h0);
        nop(1'b0, 32'h0);
        check("to_err", {31'b0, fetch_err}, 32'h1);
        check("to_req", {31'b0, imem_req}, 32'h0);
        do_reset();
        nop(1'b0, 32'h0);
        repeat (3) nop(1'b0, 32'h0);
        nop(1'b1, 32'hDEAD_BEEF);
        check("late_order", order, 32'hDEAD_BEEF);

        // stall for 4 cycles
        vcount = 0;
        if (order_valid) vcount++;
        repeat (4) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            if (order_valid) vcount++;
        end
        check("stall_pc", pc, 32'h0000_3000);
        nop(1'b0, 32'h0);
        check("stall_vcnt", vcount, 32'd5);
        check("stall_pc_adv", pc, 32'h0000_3004);
        do_reset();

        // randomized traffic
        dead = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] rs;
            rs = $urandom;
            if ($urandom_range(9) != 0) rs[1:0] = 2'b00;
            cycle($urandom_range(9) < 7, $urandom,
                  $urandom_range(9) < 3, $urandom_range(1) == 1,
                  $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
                  rs, $urandom_range(9) < 3);
            dead = (phase == 3) ? dead + 1 : 0;
            if (dead > 3 || $urandom_range(199) == 0) begin
                do_reset();
                dead = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter MAX_WAIT, default 15, maximum FETCH cycles without imem_ack before error.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 beq  input  1  branch-on-equal decode from control.
REQ-006 zero  input  1  ALU equality result for current instruction.
REQ-007 j  input  1  jump decode.
REQ-008 jal  input  1  jump-and-link decode.
REQ-009 jr  input  1  jump-register decode.
REQ-010 rs_data  input  32  GPR[rs], target for jr.
REQ-011 stall  input  1  hold current instruction in EXEC.
REQ-012 imem_req  output  1  instruction memory read request.
REQ-013 imem_addr  output  32  instruction memory byte address (= pc).
REQ-014 imem_ack  input  1  memory read data valid.
REQ-015 imem_rdata  input  32  instruction word.
REQ-016 order  output  32  current instruction word to control/datapath.
REQ-017 order_valid  output  1  order is valid and executing this cycle.
REQ-018 pc  output  32  address of current instruction.
REQ-019 pc_plus4  output  32  pc + 4, link value for jal.
REQ-020 fetch_err  output  1  sticky fault flag.

Function
REQ-021 States SHALL be IDLE, FETCH, EXEC, ERROR; 2-bit encoded.
REQ-022 IDLE SHALL go to FETCH unconditionally on the next clock.
REQ-023 imem_req SHALL equal (state==FETCH); imem_addr SHALL equal pc at all times.
REQ-024 In FETCH with imem_ack=1: order <= imem_rdata, wait counter cleared, state -> EXEC.
REQ-025 In FETCH with imem_ack=0: wait counter increments; when counter equals MAX_WAIT, state -> ERROR and fetch_err <= 1.
REQ-026 imem_ack outside FETCH SHALL be ignored; order unchanged.
REQ-027 order_valid SHALL equal (state==EXEC).
REQ-028 In EXEC with stall=1: state, pc and order held; order_valid stays 1.
REQ-029 In EXEC with stall=0: pc <= next_pc, state -> FETCH; exactly one order_valid cycle per instruction when unstalled.
REQ-030 next_pc priority: jr -> rs_data; else j or jal -> {pc_plus4[31:28], order[25:0], 2'b00}; else beq&zero -> pc_plus4 + (sign-extended order[15:0] << 2); else pc_plus4.
REQ-031 All PC arithmetic modulo 2^32; wrap from 32'hFFFF_FFFC to 0 SHALL not fault.
REQ-032 beq with zero=0 SHALL select pc_plus4; control inputs SHALL be ignored outside EXEC.
REQ-033 If next_pc[1:0] != 0 when leaving EXEC: pc unchanged, state -> ERROR, fetch_err <= 1.
REQ-034 ERROR SHALL be absorbing until reset: imem_req=0, order_valid=0, pc and order held.
REQ-035 pc_plus4 SHALL be combinational pc + 4.
REQ-036 Minimum per-instruction latency: 2 cycles (FETCH with immediate ack, then EXEC).

Reset
REQ-037 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, order=0, wait counter=0, fetch_err=0, independent of clk.
REQ-038 During reset imem_req=0, order_valid=0; reset mid-FETCH SHALL abandon the request with no capture.
REQ-039 First imem_req SHALL assert in the second cycle after rst_n rises (one IDLE cycle).

Verification
REQ-040 Reset release, ack each FETCH, imem_rdata=NOP sequence -> imem_addr 3000, 3004, 3008; order_valid pulses every 2nd cycle.
REQ-041 pc=3000, order=32'h1000_FFFF, beq=1, zero=1 -> next pc 3000; same with zero=0 -> 3004.
REQ-042 pc=3000, order=32'h0C00_0C10, jal=1 with beq=1,zero=1 -> pc 00003040, pc_plus4 during EXEC = 3004.
REQ-043 jr=1, rs_data=32'h0000_3002 -> fetch_err=1, pc stays, imem_req=0 until reset; jr=1, rs_data=3100 -> pc 3100.
REQ-044 Hold imem_ack=0 for MAX_WAIT cycles -> ERROR, fetch_err=1; ack after 3 wait cycles -> normal capture.
REQ-045 stall=1 for 4 EXEC cycles -> order_valid high 5 cycles, pc constant; assert rst_n=0 mid-FETCH -> pc=3000 same cycle.
